traffic_phase_ctrl: RTL

- Sequencing controller for a two-way intersection (main road A, side road B), clocked by the 1 Hz tick clk_out.
- Steps through all-red, green and yellow phases, and drives the lamp outputs for both roads.
- Supplies each phase's duration and an active-low load strobe to the two-digit countdown display counter.
- Also handles a latched pedestrian request that shortens main-road green, and a flashing-yellow override mode.

---
 rtl/traffic_phase_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: phase sequencer for a two-way intersection (road A main,
// road B side), advanced by the 1 Hz tick clk_out.
//
// State table
//   state       | meaning
//   S_ALLRED_A  | clearance before road A green (A red, B red)
//   S_GREEN_A   | road A green, B red; pedestrian request may shorten it
//   S_YELLOW_A  | road A yellow, B red
//   S_ALLRED_B  | clearance before road B green (A red, B red)
//   S_GREEN_B   | road B green, A red, walk lamp on
//   S_YELLOW_B  | road B yellow, A red
//   S_FLASH     | override: both yellow / all off on alternate ticks
//
// Ports
//   clk_out    in   1 Hz tick, rising edge active
//   reset      in   asynchronous, active-low reset
//   flash      in   level, 1 = flashing-yellow override
//   ped_req_n  in   active-low pedestrian button, sampled on clk_out
//   light_a    out  road A {red,yellow,green}, one-hot (all 0 in flash-off)
//   light_b    out  road B {red,yellow,green}
//   ped_walk   out  walk lamp for pedestrians crossing road A
//   count      out  duration of the current phase (display load value)
//   load_n     out  active-low load strobe, low in the first cycle of a phase
//   remain     out  seconds left in the current phase, N..1
module traffic_phase_ctrl #(
  parameter int GREEN_A  = 20,
  parameter int GREEN_B  = 15,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_CUT  = 5
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       flash,
  input  logic       ped_req_n,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       ped_walk,
  output logic [6:0] count,
  output logic       load_n,
  output logic [6:0] remain
);

  typedef enum logic [2:0] {
    S_ALLRED_A, S_GREEN_A, S_YELLOW_A, S_ALLRED_B, S_GREEN_B, S_YELLOW_B, S_FLASH
  } state_t;

  // A zero duration would stall the phase, so it is promoted to one second.
  function automatic logic [6:0] dur(input int p);
    return (p <= 0) ? 7'd1 : 7'(p);
  endfunction

  localparam logic [6:0] D_GREEN_A = dur(GREEN_A);
  localparam logic [6:0] D_GREEN_B = dur(GREEN_B);
  localparam logic [6:0] D_YELLOW  = dur(YELLOW_T);
  localparam logic [6:0] D_ALLRED  = dur(ALLRED_T);
  localparam logic [6:0] D_PED_CUT = dur(PED_CUT);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  function automatic logic [6:0] phase_dur(input state_t s);
    case (s)
      S_GREEN_A:  return D_GREEN_A;
      S_GREEN_B:  return D_GREEN_B;
      S_YELLOW_A,
      S_YELLOW_B: return D_YELLOW;
      S_FLASH:    return 7'd0;
      default:    return D_ALLRED;
    endcase
  endfunction

  state_t     state_q, state_d, next_phase;
  logic [6:0] remain_q, remain_d;
  logic [6:0] count_q, count_d;
  logic       load_n_q, load_n_d;
  logic       ped_q, ped_d, ped_eff;
  logic       fph_q, fph_d;
  logic [2:0] light_a_q, light_a_d;
  logic [2:0] light_b_q, light_b_d;
  logic       walk_q, walk_d;

  // A press on the current edge counts immediately, not one tick later.
  assign ped_eff = ped_q | ~ped_req_n;

  always_comb begin
    case (state_q)
      S_ALLRED_A: next_phase = S_GREEN_A;
      S_GREEN_A:  next_phase = S_YELLOW_A;
      S_YELLOW_A: next_phase = S_ALLRED_B;
      S_ALLRED_B: next_phase = S_GREEN_B;
      S_GREEN_B:  next_phase = S_YELLOW_B;
      default:    next_phase = S_ALLRED_A;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    count_d  = count_q;
    load_n_d = 1'b1;
    fph_d    = fph_q;
    ped_d    = ped_eff;

    if (flash) begin
      state_d  = S_FLASH;
      fph_d    = (state_q == S_FLASH) ? ~fph_q : 1'b1;
      remain_d = 7'd0;
      count_d  = 7'd0;
      ped_d    = 1'b0;
    end else if (state_q == S_FLASH) begin
      state_d  = S_ALLRED_A;
      remain_d = D_ALLRED;
      count_d  = D_ALLRED;
      load_n_d = 1'b0;
      ped_d    = 1'b0;
    end else if (remain_q <= 7'd1) begin
      state_d  = next_phase;
      remain_d = phase_dur(next_phase);
      count_d  = phase_dur(next_phase);
      load_n_d = 1'b0;
      if (next_phase == S_GREEN_B) ped_d = 1'b0;
    end else if (state_q == S_GREEN_A && ped_eff && remain_q > D_PED_CUT) begin
      // Shortened green keeps the original count and issues no load strobe.
      remain_d = D_PED_CUT;
    end else begin
      remain_d = remain_q - 7'd1;
    end
  end

  // Lamps decode the next state so they change on the same edge as the state.
  always_comb begin
    light_a_d = L_RED;
    light_b_d = L_RED;
    walk_d    = 1'b0;
    case (state_d)
      S_GREEN_A:  light_a_d = L_GRN;
      S_YELLOW_A: light_a_d = L_YEL;
      S_GREEN_B: begin
        light_b_d = L_GRN;
        walk_d    = 1'b1;
      end
      S_YELLOW_B: light_b_d = L_YEL;
      S_FLASH: begin
        light_a_d = fph_d ? L_YEL : L_OFF;
        light_b_d = fph_d ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state_q   <= S_ALLRED_A;
      remain_q  <= D_ALLRED;
      count_q   <= D_ALLRED;
      load_n_q  <= 1'b0;
      ped_q     <= 1'b0;
      fph_q     <= 1'b0;
      light_a_q <= L_RED;
      light_b_q <= L_RED;
      walk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      count_q   <= count_d;
      load_n_q  <= load_n_d;
      ped_q     <= ped_d;
      fph_q     <= fph_d;
      light_a_q <= light_a_d;
      light_b_q <= light_b_d;
      walk_q    <= walk_d;
    end
  end

  assign light_a  = light_a_q;
  assign light_b  = light_b_q;
  assign ped_walk = walk_q;
  assign count    = count_q;
  assign load_n   = load_n_q;
  assign remain   = remain_q;

endmodule
